// File: rtl/conv_window_fetch.sv
// Walks a matrix x matrix channel and gathers each 3x3 zero-padded neighbourhood
// from the pixel memory into one packed window behind a valid/ready handshake.
module conv_window_fetch #(
  parameter int SIZE_1           = 11,
  parameter int SIZE_address_pix = 13,
  parameter int picture_size     = 28
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [4:0]                  matrix,
  input  logic [SIZE_address_pix-1:0] mem_base,
  output logic                        re_p,
  output logic [SIZE_address_pix-1:0] read_addressp,
  input  logic [SIZE_1-1:0]           qp,
  output logic [9*SIZE_1-1:0]         window,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int CW = $clog2(picture_size + 1);
  localparam int AW = SIZE_address_pix;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [3:0]    k;
  logic [CW-1:0] r;
  logic [CW-1:0] c;
  logic [AW-1:0] row_base;
  logic [CW-1:0] m_last_q;
  logic [AW-1:0] m_ext_q;

  logic [1:0]    rs;
  logic [1:0]    cs;
  logic          row_ok;
  logic          col_ok;
  logic          in_bounds;
  logic [AW-1:0] row_off;
  logic [AW-1:0] col_off;
  logic [AW-1:0] nb_addr;
  logic          start_ok;
  logic          at_last;

  logic          vld_p1;
  logic [3:0]    slot_p1;
  logic          pad_p1;

  logic signed [SIZE_1-1:0] win_p2 [0:8];

  function automatic logic [1:0] slot_row(input logic [3:0] kk);
    case (kk)
      4'd0, 4'd1, 4'd2: slot_row = 2'd0;
      4'd3, 4'd4, 4'd5: slot_row = 2'd1;
      default:          slot_row = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] slot_col(input logic [3:0] kk);
    case (kk)
      4'd0, 4'd3, 4'd6: slot_col = 2'd0;
      4'd1, 4'd4, 4'd7: slot_col = 2'd1;
      default:          slot_col = 2'd2;
    endcase
  endfunction

  assign start_ok = start && (matrix != 5'd0) && (int'(matrix) <= picture_size);
  assign at_last  = (r == m_last_q) && (c == m_last_q);

  // Neighbour address is built from row_base = mem_base + r*matrix, so no multiplier.
  always_comb begin
    rs      = slot_row(k);
    cs      = slot_col(k);
    row_ok  = 1'b1;
    col_ok  = 1'b1;
    row_off = '0;
    col_off = '0;
    if (rs == 2'd0) begin
      row_ok  = (r != '0);
      row_off = -m_ext_q;
    end else if (rs == 2'd2) begin
      row_ok  = (r != m_last_q);
      row_off = m_ext_q;
    end
    if (cs == 2'd0) begin
      col_ok  = (c != '0);
      col_off = '1;
    end else if (cs == 2'd2) begin
      col_ok  = (c != m_last_q);
      col_off = AW'(1);
    end
    in_bounds = row_ok && col_ok;
    nb_addr   = row_base + row_off + AW'(c) + col_off;
  end

  assign re_p          = (state == S_FETCH) && in_bounds;
  assign read_addressp = re_p ? nb_addr : '0;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      r         <= '0;
      c         <= '0;
      win_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state <= S_FETCH;
            k     <= '0;
            r     <= '0;
            c     <= '0;
          end
        end
        S_FETCH: begin
          if (k == 4'd8) begin
            k     <= '0;
            state <= S_DRAIN;
          end else begin
            k <= k + 4'd1;
          end
        end
        S_DRAIN: begin
          state     <= S_HOLD;
          win_valid <= 1'b1;
        end
        S_HOLD: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (at_last) begin
              state <= S_DONE;
            end else begin
              state <= S_FETCH;
              if (c == m_last_q) begin
                c <= '0;
                r <= r + CW'(1);
              end else begin
                c <= c + CW'(1);
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Scan geometry: latched at an accepted start, row_base steps by one row on wrap.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start_ok) begin
      row_base <= mem_base;
      m_last_q <= CW'(matrix - 5'd1);
      m_ext_q  <= AW'(matrix);
    end else if (state == S_HOLD && win_ready && win_valid && !at_last && c == m_last_q) begin
      row_base <= row_base + m_ext_q;
    end
  end

  // p1: slot tag travels one cycle behind the issue, aligned with qp
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= (state == S_FETCH);
    end
  end

  always_ff @(posedge clk) begin
    slot_p1 <= k;
    pad_p1  <= !in_bounds;
  end

  // p2: window slots; pad slots load zero and never look at qp
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) win_p2[i] <= '0;
    end else if (vld_p1) begin
      win_p2[slot_p1] <= pad_p1 ? '0 : $signed(qp);
    end
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < 9; i++) window[i*SIZE_1 +: SIZE_1] = win_p2[i];
  end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Scoreboard bench for conv_window_fetch: a behavioural memory answers reads and a
// direct-formula model predicts every window, read count and handshake timing.
module tb_conv_window_fetch;

  localparam int DW = 11;
  localparam int AW = 13;
  localparam int WW = 9 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4:0]    matrix;
  logic [AW-1:0] mem_base;
  logic          re_p;
  logic [AW-1:0] read_addressp;
  logic [DW-1:0] qp;
  logic [WW-1:0] window;
  logic          win_valid;
  logic          win_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int last_addr = -1;
  int exp_reads = 0;
  int exp_total = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] got_q[$];

  conv_window_fetch dut (
    .clk(clk), .rst(rst), .start(start), .matrix(matrix), .mem_base(mem_base),
    .re_p(re_p), .read_addressp(read_addressp), .qp(qp), .window(window),
    .win_valid(win_valid), .win_ready(win_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] mem_val(input int a);
    return a[DW-1:0];
  endfunction

  // Pixel memory: one-cycle read latency, garbage on cycles with no read.
  always @(posedge clk) qp <= re_p ? mem_val(int'(read_addressp)) : DW'($urandom);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (re_p) begin
        rd_cnt++;
        last_addr = int'(read_addressp);
      end
      if (done) done_cnt++;
      if (win_valid && win_ready) begin
        got_q.push_back(window);
        if (exp_q.size() == 0) chk("extra_win", 128'(got_q.size()), 128'(exp_total));
        else chk("window", 128'(window), 128'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [WW-1:0] pack9(input int v[9]);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[i*DW +: DW] = v[i][DW-1:0];
    return w;
  endfunction

  task automatic push_scan(input int m, input int base);
    exp_reads = 0;
    exp_total = m * m;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < m; c++) begin
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) begin
          int rr, cc;
          rr = r + i / 3 - 1;
          cc = c + i % 3 - 1;
          if (rr >= 0 && rr < m && cc >= 0 && cc < m) begin
            w[i*DW +: DW] = mem_val((base + rr * m + cc) % 8192);
            exp_reads++;
          end
        end
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    rd_cnt = 0;
    done_cnt = 0;
    last_addr = -1;
  endtask

  task automatic pulse_start(input int m, input int base);
    @(posedge clk); #1;
    start = 1'b1;
    matrix = 5'(m);
    mem_base = AW'(base);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_scan(input int m);
    int n;
    n = 0;
    while (!done && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 128'(done), 128'(1));
    @(posedge clk); #1;
    chk("win_count", 128'(got_q.size()), 128'(m * m));
    chk("reads", 128'(rd_cnt), 128'(exp_reads));
    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse", 128'(done_cnt), 128'(1));
    chk("idle_busy", 128'(busy), 128'(0));
  endtask

  task automatic run_scan(input int m, input int base);
    int lat, n;
    clear_sb();
    push_scan(m, base);
    pulse_start(m, base);
    lat = 1;
    while (!win_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 128'(lat), 128'(11));
    n = 0;
    while (!done && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scan_cycles", 128'(lat + n), 128'(11 * m * m + 1));
    finish_scan(m);
  endtask

  initial begin
    logic [WW-1:0] snap;
    int n;
    rst = 1'b1;
    start = 1'b0;
    matrix = 5'd4;
    mem_base = '0;
    win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 128'({re_p, read_addressp, window, win_valid, busy, done}), 128'(0));
    rst = 1'b0;

    // Full 4x4 scan from address 0
    run_scan(4, 0);
    chk("win0", 128'(got_q[0]), 128'(pack9('{0, 0, 0, 0, 0, 1, 0, 4, 5})));
    chk("win5", 128'(got_q[5]), 128'(pack9('{0, 1, 2, 4, 5, 6, 8, 9, 10})));
    chk("win15", 128'(got_q[15]), 128'(pack9('{10, 11, 0, 14, 15, 0, 0, 0, 0})));

    // Single-pixel map
    run_scan(1, 100);
    chk("m1_win", 128'(got_q[0]), 128'(pack9('{0, 0, 0, 0, 100, 0, 0, 0, 0})));
    chk("m1_addr", 128'(last_addr), 128'(100));

    // Backpressure on the second window
    clear_sb();
    push_scan(4, 0);
    pulse_start(4, 0);
    n = 0;
    while (got_q.size() < 1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    win_ready = 1'b0;
    n = 0;
    while (!win_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_reach", 128'(win_valid), 128'(1));
    snap = window;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_valid", 128'(win_valid), 128'(1));
      chk("stall_window", 128'(window), 128'(snap));
      chk("stall_rep", 128'(re_p), 128'(0));
    end
    win_ready = 1'b1;
    @(posedge clk); #1;
    chk("resume_valid", 128'(win_valid), 128'(0));
    chk("resume_count", 128'(got_q.size()), 128'(2));
    finish_scan(4);

    // Reset while fetching the third window, then a clean rescan
    clear_sb();
    push_scan(4, 0);
    pulse_start(4, 0);
    n = 0;
    while (got_q.size() < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", 128'({re_p, read_addressp, window, win_valid, busy, done}), 128'(0));
    rst = 1'b0;
    clear_sb();
    repeat (15) @(posedge clk);
    #1;
    chk("abort_done", 128'(done_cnt), 128'(0));
    chk("abort_reads", 128'(rd_cnt), 128'(0));
    run_scan(3, 37);

    // Start while busy must not disturb the running scan
    clear_sb();
    push_scan(4, 5);
    pulse_start(4, 5);
    repeat (3) @(posedge clk);
    pulse_start(2, 0);
    finish_scan(4);
    chk("busy_reads100", 128'(rd_cnt), 128'(100));

    // Out-of-range sizes are ignored
    for (int i = 0; i < 2; i++) begin
      clear_sb();
      pulse_start((i == 0) ? 0 : 29, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("oor_busy", 128'(busy), 128'(0));
      chk("oor_reads", 128'(rd_cnt), 128'(0));
    end

    // Addresses wrap modulo the address space
    run_scan(5, 8180);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
- Sits between the pixel memory's read port and the 3x3 convolution engine.
- Scans one feature-map channel of run-time size matrix x matrix, stored row-major from base address mem_base.
- For each output position it fetches the 9-pixel neighbourhood, applying zero padding at the borders.
- Presents the neighbourhood as one packed window under a valid/ready handshake.

Parameters:
SIZE_1, 11, pixel data width in bits (signed).
SIZE_address_pix, 13, pixel memory address width.
picture_size, 28, maximum supported matrix value; sets counter widths.

Ports:
clk  input  1  clock, all logic on posedge.
rst  input  1  synchronous active-high reset.
start  input  1  single-cycle pulse; begins a scan; ignored unless idle.
matrix  input  5  feature-map side length, 1..picture_size; sampled on start.
mem_base  input  SIZE_address_pix  channel base address; sampled on start.
re_p  output  1  pixel memory read enable.
read_addressp  output  SIZE_address_pix  pixel memory read address.
qp  input  SIZE_1  pixel memory read data; valid the cycle after re_p.
window  output  9*SIZE_1  packed neighbourhood; slot k occupies bits [(k+1)*SIZE_1-1 : k*SIZE_1].
win_valid  output  1  window holds a complete neighbourhood.
win_ready  input  1  consumer accepts the window when win_valid && win_ready.
busy  output  1  high from the cycle after start until done.
done  output  1  single-cycle pulse after the last window is accepted.

Behaviour:
- Reset: all outputs 0, including window; FSM goes to IDLE; counters r=c=k=0.
- Reset wins over every other input in the same cycle. Reset mid-scan aborts immediately: no done, re_p=0 next cycle.
- Slot order: k=0..8 maps to (dy,dx) = (-1,-1),(-1,0),(-1,1),(0,-1),(0,0),(0,1),(1,-1),(1,0),(1,1), row-major, k=0 top-left.
- Neighbour address: mem_base + (r+dy)*matrix + (c+dx), computed modulo 2^SIZE_address_pix. Incremental computation is allowed; results must be exact.
- FSM states:
  - IDLE: busy=0. start -> FETCH with r=c=k=0; latch matrix and mem_base.
  - FETCH: one slot per cycle, 9 cycles.
    - In-bounds neighbour (0<=r+dy<matrix, 0<=c+dx<matrix): re_p=1 with the address.
    - Out-of-bounds neighbour: re_p=0 and the slot is marked pad.
    - A registered tag (slot index, pad flag) follows each issue by one cycle. The slot captures qp, or 0 if pad; qp is never captured for pad slots.
    - After k=8 issues -> DRAIN.
  - DRAIN: 1 cycle, captures slot 8. win_valid=1 from the next cycle -> HOLD.
  - HOLD: win_valid=1; window stable; re_p=0.
    - On accept: if (r,c) is not (matrix-1,matrix-1), advance c (wrapping to 0 and incrementing r) and go to FETCH with win_valid=0 next cycle.
    - Otherwise -> DONE.
  - DONE: done=1 for one cycle, busy=0 from the next cycle -> IDLE.
- Latency: start to first win_valid = 11 cycles. Steady state = 11 cycles per window when win_ready is held high.
- Backpressure: while win_valid && !win_ready, window, win_valid and re_p=0 hold indefinitely.
- start while busy: ignored, with no effect on the latched matrix or mem_base.
- matrix=1: exactly one window; only slot 4 is read (at mem_base); all other slots are 0.
- Out-of-range matrix (0 or >picture_size): start ignored, stays IDLE.
- re_p is never asserted outside FETCH. Each scan performs exactly (number of in-bounds neighbours) reads.

Test Plan:
- mem[i]=i, matrix=4, mem_base=0, win_ready=1 -> first window slots 0..8 = {0,0,0,0,0,1,0,4,5}; win_valid first high 11 cycles after start.
- Same setup, 6th window (r=1,c=1) -> {0,1,2,4,5,6,8,9,10}. Last window (3,3) -> {10,11,0,14,15,0,0,0,0}. Exactly 16 windows, then a 1-cycle done.
- mem_base=100, matrix=1 -> one window {0,0,0,0,mem[100],0,0,0,0}; exactly one re_p cycle, at address 100; done follows acceptance.
- win_ready low for 5 cycles on window 2 -> window bits and win_valid constant, re_p=0 throughout; the scan resumes on the accept cycle.
- rst asserted during FETCH of window 3 -> next cycle all outputs 0, IDLE; a new start afterwards scans from (0,0) correctly.
- start pulsed while busy with matrix=2 -> ignored; the original matrix=4 scan still yields 16 windows. Counting re_p pulses over a full matrix=4 scan gives 100 reads.
